// File: rtl/port_status_poller_if.sv
// Poll/response bus between the poller and the downstream ports, plus the
// upstream status outputs and the valid/ready event channel to the hub controller.
interface port_status_poller_if #(
  parameter int NUM_PORTS    = 4,
  parameter int STATUS_WIDTH = 8
);
  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]              polling_clock;
  logic [NUM_PORTS-1:0]              poll_req;
  logic [NUM_PORTS-1:0]              poll_resp_valid;
  logic [NUM_PORTS*STATUS_WIDTH-1:0] poll_resp_data;
  logic [NUM_PORTS*STATUS_WIDTH-1:0] status_table;
  logic [NUM_PORTS-1:0]              change_bitmap;
  logic [NUM_PORTS-1:0]              timeout_err;
  logic                              evt_valid;
  logic [IDX_W-1:0]                  evt_port;
  logic [STATUS_WIDTH-1:0]           evt_status;
  logic                              evt_ready;

  modport master (
    input  polling_clock, poll_resp_valid, poll_resp_data, evt_ready,
    output poll_req, status_table, change_bitmap, timeout_err,
           evt_valid, evt_port, evt_status
  );

  modport slave (
    output polling_clock, poll_resp_valid, poll_resp_data, evt_ready,
    input  poll_req, status_table, change_bitmap, timeout_err,
           evt_valid, evt_port, evt_status
  );
endinterface

// File: rtl/port_status_poller.sv
// Polls downstream ports on rising polling_clock strobes, keeps a status table,
// and reports status changes (including timeouts treated as disconnects) upstream.
module port_status_poller #(
  parameter int NUM_PORTS    = 4,
  parameter int STATUS_WIDTH = 8,
  parameter int RESP_TIMEOUT = 16
) (
  input logic                    clock,
  input logic                    reset,
  port_status_poller_if.master   bus
);
  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(RESP_TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, REPORT} state_t;

  state_t                  state_reg;
  logic [NUM_PORTS-1:0]    strobe_prev_reg;
  logic [NUM_PORTS-1:0]    pending_reg;
  logic [NUM_PORTS-1:0]    poll_req_reg;
  logic [NUM_PORTS-1:0]    change_reg;
  logic [NUM_PORTS-1:0]    timeout_reg;
  logic [STATUS_WIDTH-1:0] table_reg [NUM_PORTS];
  logic [IDX_W-1:0]        port_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    evt_valid_reg;
  logic [IDX_W-1:0]        evt_port_reg;
  logic [STATUS_WIDTH-1:0] evt_status_reg;

  logic [NUM_PORTS-1:0]    rise;
  logic [NUM_PORTS-1:0]    clear_sel;
  logic                    sel_any;
  logic [IDX_W-1:0]        sel_idx;
  logic [STATUS_WIDTH-1:0] resp_word [NUM_PORTS];
  logic [STATUS_WIDTH-1:0] resp_cur;
  logic [STATUS_WIDTH-1:0] old_cur;
  logic                    resp_hit;
  logic                    timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign resp_word[gi] = bus.poll_resp_data[gi*STATUS_WIDTH +: STATUS_WIDTH];
      assign bus.status_table[gi*STATUS_WIDTH +: STATUS_WIDTH] = table_reg[gi];
    end
  endgenerate

  assign rise        = bus.polling_clock & ~strobe_prev_reg;
  assign sel_any     = |pending_reg;
  assign clear_sel   = (state_reg == IDLE && sel_any) ? (NUM_PORTS'(1) << sel_idx) : '0;
  assign resp_cur    = resp_word[port_reg];
  assign old_cur     = table_reg[port_reg];
  assign resp_hit    = bus.poll_resp_valid[port_reg];
  assign timeout_hit = (cnt_reg == CNT_W'(RESP_TIMEOUT - 1));

  // Lowest-index pending port wins.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (pending_reg[i]) sel_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      strobe_prev_reg <= '0;
      pending_reg     <= '0;
      poll_req_reg    <= '0;
      change_reg      <= '0;
      timeout_reg     <= '0;
      port_reg        <= '0;
      cnt_reg         <= '0;
      evt_valid_reg   <= 1'b0;
      evt_port_reg    <= '0;
      evt_status_reg  <= '0;
      for (int i = 0; i < NUM_PORTS; i++) table_reg[i] <= '0;
    end else begin
      strobe_prev_reg <= bus.polling_clock;
      // A new edge on the port being selected re-arms it, so no strobe is lost.
      pending_reg     <= (pending_reg & ~clear_sel) | rise;

      case (state_reg)
        IDLE: begin
          if (sel_any) begin
            port_reg     <= sel_idx;
            poll_req_reg <= clear_sel;
            state_reg    <= REQ;
          end
        end
        REQ: begin
          poll_req_reg <= '0;
          cnt_reg      <= '0;
          state_reg    <= WAIT;
        end
        WAIT: begin
          if (resp_hit) begin
            table_reg[port_reg]   <= resp_cur;
            timeout_reg[port_reg] <= 1'b0;
            if (resp_cur != old_cur) begin
              change_reg[port_reg] <= 1'b1;
              evt_valid_reg        <= 1'b1;
              evt_port_reg         <= port_reg;
              evt_status_reg       <= resp_cur;
              state_reg            <= REPORT;
            end else begin
              state_reg <= IDLE;
            end
          end else if (timeout_hit) begin
            // Silent port is treated as disconnected.
            table_reg[port_reg]   <= '0;
            timeout_reg[port_reg] <= 1'b1;
            if (old_cur != '0) begin
              change_reg[port_reg] <= 1'b1;
              evt_valid_reg        <= 1'b1;
              evt_port_reg         <= port_reg;
              evt_status_reg       <= '0;
              state_reg            <= REPORT;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        REPORT: begin
          if (bus.evt_ready) begin
            change_reg[port_reg] <= 1'b0;
            evt_valid_reg        <= 1'b0;
            evt_port_reg         <= '0;
            evt_status_reg       <= '0;
            state_reg            <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.poll_req      = poll_req_reg;
  assign bus.change_bitmap = change_reg;
  assign bus.timeout_err   = timeout_reg;
  assign bus.evt_valid     = evt_valid_reg;
  assign bus.evt_port      = evt_port_reg;
  assign bus.evt_status    = evt_status_reg;
endmodule
